fifo_umbral: RTL and testbench

//  Synchronous FIFO for one lane, upstream of maquina_estados.

---
 rtl/fifo_umbral_if.sv | 30 +++
 rtl/fifo_umbral.sv | 89 ++++++++
 tb/tb_fifo_umbral.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_umbral_if.sv
// Handshake and status bundle between a lane producer/consumer and fifo_umbral.
// The master drives push/pop requests and thresholds; the slave (the FIFO) returns data and flags.
interface fifo_umbral_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_enable;
  logic                  rd_enable;
  logic [DATA_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH-1:0] umbral_L;
  logic [ADDR_WIDTH-1:0] umbral_H;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic                  error;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output wr_enable, rd_enable, data_in, umbral_L, umbral_H,
    input  data_out, valid_out, empty, full, almost_empty, almost_full, error, count
  );

  modport slave (
    input  wr_enable, rd_enable, data_in, umbral_L, umbral_H,
    output data_out, valid_out, empty, full, almost_empty, almost_full, error, count
  );
endinterface

// File: rtl/fifo_umbral.sv
// Single-clock lane FIFO with registered read data, threshold flags and a sticky
// overflow/underflow error; its empty flag feeds maquina_estados.
module fifo_umbral #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic          clk,
  input  logic          reset_L,
  fifo_umbral_if.slave  bus
);
  localparam int                  DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_next;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  valid_q;
  logic                  error_q;

  logic is_empty;
  logic is_full;
  logic wr_ok;
  logic rd_ok;
  logic bad_req;

  // A read on an empty FIFO is never bypassed by a same-cycle write,
  // and a write into a full FIFO is only taken when a read frees a slot.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    is_empty   = (count_q == '0);
    is_full    = (count_q == DEPTH_C);
    wr_ok      = bus.wr_enable && (!is_full || bus.rd_enable);
    rd_ok      = bus.rd_enable && !is_empty;
    bad_req    = (bus.wr_enable && is_full && !bus.rd_enable) ||
                 (bus.rd_enable && is_empty);
    count_next = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_q + 1'b1;
      2'b01:   count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
  end

  // NOTE: the storage array has no reset; only the pointers and count define which words are live.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        data_out_q <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + 1'b1;
      end
      valid_q <= rd_ok;
      count_q <= count_next;
      if (bad_req) begin
        error_q <= 1'b1;
      end
    end
  end

  // Flags follow the thresholds combinationally so a threshold change shows up the same cycle.
  assign bus.empty        = is_empty;
  assign bus.full         = is_full;
  assign bus.almost_empty = (count_q <= {1'b0, bus.umbral_L});
  assign bus.almost_full  = (count_q >= {1'b0, bus.umbral_H});
  assign bus.count        = count_q;
  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_fifo_umbral.sv
// Self-checking bench for fifo_umbral: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fifo_umbral;
  localparam int DW    = 6;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  fifo_umbral_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: contents as a queue plus the observable registered outputs.
  logic [DW-1:0] q[$];
  bit            m_err;
  bit            m_valid;
  logic [DW-1:0] m_dout;

  task automatic model_reset();
    q.delete();
    m_err   = 1'b0;
    m_valid = 1'b0;
    m_dout  = '0;
  endtask

  task automatic set_idle();
    bus.wr_enable = 1'b0;
    bus.rd_enable = 1'b0;
    bus.data_in   = '0;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    set_idle();
    model_reset();
    #3;
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  // Drives one clock of requests and advances the model; returns 1 time unit after the edge.
  task automatic cycle(input bit wr, input bit rd, input logic [DW-1:0] d);
    bit full_m;
    bit empty_m;
    bit wacc;
    bit racc;
    @(negedge clk);
    bus.wr_enable = wr;
    bus.rd_enable = rd;
    bus.data_in   = d;
    full_m  = (q.size() == DEPTH);
    empty_m = (q.size() == 0);
    wacc    = wr && (!full_m || rd);
    racc    = rd && !empty_m;
    if ((wr && full_m && !rd) || (rd && empty_m)) m_err = 1'b1;
    m_valid = racc;
    if (racc) m_dout = q.pop_front();
    if (wacc) q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    bus.umbral_L = 3'd2;
    bus.umbral_H = 3'd6;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, DW'(i + 1));
    cycle(1'b0, 1'b1, '0);
    n_cmp++;
    if (bus.count !== 4'd5 || bus.valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre: count=%0d valid=%0b required count=5 valid=1", bus.count, bus.valid_out);
    end
    #1 reset_L = 1'b0;
    #1;
    n_cmp++;
    if (bus.count !== 4'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d required 0", bus.count);
    end
    n_cmp++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: e/f/ae/af=%b%b%b%b required 1010", bus.empty, bus.full, bus.almost_empty, bus.almost_full);
    end
    n_cmp++;
    if (bus.valid_out !== 1'b0 || bus.error !== 1'b0 || bus.data_out !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: valid=%0b error=%0b data=%0h required 0/0/0", bus.valid_out, bus.error, bus.data_out);
    end
    bus.umbral_H = 3'd0;
    #1;
    n_cmp++;
    if (bus.almost_full !== 1'b1) begin
      n_fail++; $display("FAIL reset_af_h0: got %0b required 1", bus.almost_full);
    end
    bus.umbral_H = 3'd6;
    set_idle();
    model_reset();
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic test_order();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, DW'(i + 1));
      n_cmp++;
      if (bus.full !== (i == DEPTH - 1)) begin
        n_fail++; $display("FAIL order_full[%0d]: got %0b required %0b", i, bus.full, (i == DEPTH - 1));
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, '0);
      n_cmp++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== DW'(i + 1)) begin
        n_fail++;
        $display("FAIL order_pop[%0d]: valid=%0b data=%0h required valid=1 data=%0h", i, bus.valid_out, bus.data_out, i + 1);
      end
    end
    n_cmp++;
    if (bus.empty !== 1'b1) begin
      n_fail++; $display("FAIL order_empty: got %0b required 1", bus.empty);
    end
    cycle(1'b0, 1'b0, '0);
    n_cmp++;
    if (bus.valid_out !== 1'b0 || bus.data_out !== 6'h08) begin
      n_fail++; $display("FAIL order_hold: valid=%0b data=%0h required 0/08", bus.valid_out, bus.data_out);
    end
  endtask

  task automatic test_thresholds();
    do_reset();
    bus.umbral_L = 3'd2;
    bus.umbral_H = 3'd6;
    for (int n = 0; n <= DEPTH; n++) begin
      n_cmp++;
      if (bus.count !== 4'(n) || bus.almost_empty !== (n <= 2) ||
          bus.almost_full !== (n >= 6) || bus.full !== (n == DEPTH)) begin
        n_fail++;
        $display("FAIL thr[%0d]: count=%0d ae=%0b af=%0b full=%0b required ae=%0b af=%0b full=%0b",
                 n, bus.count, bus.almost_empty, bus.almost_full, bus.full, (n <= 2), (n >= 6), (n == DEPTH));
      end
      if (n < DEPTH) cycle(1'b1, 1'b0, DW'($urandom));
    end
    bus.umbral_L = 3'd7;
    #1;
    n_cmp++;
    if (bus.almost_empty !== 1'b0) begin
      n_fail++; $display("FAIL thr_l7_at8: got %0b required 0", bus.almost_empty);
    end
    bus.umbral_L = 3'd2;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'(8'h10 + i));
    n_cmp++;
    if (bus.error !== 1'b0) begin
      n_fail++; $display("FAIL ovf_pre_error: got %0b required 0", bus.error);
    end
    cycle(1'b1, 1'b0, 6'h3F);
    n_cmp++;
    if (bus.count !== 4'd8 || bus.error !== 1'b1 || bus.full !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_state: count=%0d error=%0b full=%0b required 8/1/1", bus.count, bus.error, bus.full);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, '0);
      n_cmp++;
      if (bus.data_out === 6'h3F || bus.data_out !== DW'(8'h10 + i) || bus.valid_out !== 1'b1) begin
        n_fail++;
        $display("FAIL ovf_pop[%0d]: data=%0h valid=%0b required data=%0h valid=1", i, bus.data_out, bus.valid_out, 8'h10 + i);
      end
    end
    n_cmp++;
    if (bus.error !== 1'b1 || bus.empty !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: error=%0b empty=%0b required 1/1", bus.error, bus.empty);
    end
  endtask

  task automatic test_full_rw();
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'(8'h20 + i));
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, DW'(8'h28 + i));
      n_cmp++;
      if (bus.count !== 4'd8 || bus.error !== 1'b0 || bus.valid_out !== 1'b1 || bus.data_out !== DW'(8'h20 + i)) begin
        n_fail++;
        $display("FAIL full_rw[%0d]: count=%0d error=%0b valid=%0b data=%0h required 8/0/1/%0h",
                 i, bus.count, bus.error, bus.valid_out, bus.data_out, 8'h20 + i);
      end
    end
  endtask

  task automatic test_empty_rw();
    do_reset();
    cycle(1'b1, 1'b1, 6'h15);
    n_cmp++;
    if (bus.count !== 4'd1 || bus.valid_out !== 1'b0 || bus.error !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_rw: count=%0d valid=%0b error=%0b required 1/0/1", bus.count, bus.valid_out, bus.error);
    end
    cycle(1'b0, 1'b1, '0);
    n_cmp++;
    if (bus.data_out !== 6'h15 || bus.valid_out !== 1'b1 || bus.count !== 4'd0) begin
      n_fail++;
      $display("FAIL empty_rw_pop: data=%0h valid=%0b count=%0d required 15/1/0", bus.data_out, bus.valid_out, bus.count);
    end
  endtask

  task automatic test_random();
    bit            wr;
    bit            rd;
    logic [AW:0]   exp_cnt;
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 0) do_reset();
      if ($urandom_range(0, 9) == 0) begin
        bus.umbral_L = AW'($urandom);
        bus.umbral_H = AW'($urandom);
      end
      wr = ($urandom_range(0, 99) < 55);
      rd = ($urandom_range(0, 99) < 45);
      // Keep error-causing requests rare so the sticky flag stays low for stretches.
      if (wr && !rd && q.size() == DEPTH && $urandom_range(0, 3) != 0) wr = 1'b0;
      if (rd && q.size() == 0 && $urandom_range(0, 3) != 0) rd = 1'b0;
      cycle(wr, rd, DW'($urandom));
      exp_cnt = (AW + 1)'(q.size());
      n_cmp++;
      if (bus.count !== exp_cnt || bus.empty !== (q.size() == 0) || bus.full !== (q.size() == DEPTH)) begin
        n_fail++;
        $display("FAIL rnd_count[%0d]: count=%0d empty=%0b full=%0b required count=%0d", i, bus.count, bus.empty, bus.full, exp_cnt);
      end
      n_cmp++;
      if (bus.almost_empty !== (q.size() <= int'(bus.umbral_L)) || bus.almost_full !== (q.size() >= int'(bus.umbral_H))) begin
        n_fail++;
        $display("FAIL rnd_thr[%0d]: ae=%0b af=%0b count=%0d L=%0d H=%0d", i, bus.almost_empty, bus.almost_full, q.size(), bus.umbral_L, bus.umbral_H);
      end
      n_cmp++;
      if (bus.valid_out !== m_valid || bus.data_out !== m_dout || bus.error !== m_err) begin
        n_fail++;
        $display("FAIL rnd_out[%0d]: valid=%0b data=%0h error=%0b required %0b/%0h/%0b",
                 i, bus.valid_out, bus.data_out, bus.error, m_valid, m_dout, m_err);
      end
    end
  endtask

  initial begin
    reset_L      = 1'b0;
    bus.umbral_L = 3'd2;
    bus.umbral_H = 3'd6;
    set_idle();
    model_reset();
    test_reset();
    test_order();
    test_thresholds();
    test_overflow();
    test_full_rw();
    test_empty_rw();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
